uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- UART transmit sequencer for 8-bit words.
- Accepts a parallel byte on a valid/ready handshake and loads it into an internal parallel-in/serial-out shift register.
- Times each bit period with a baud counter and frames the data on txd: start bit, 8 data bits LSB first, optional parity, then stop bit(s).
- Sits between the byte producer (host FIFO/register interface) and the TX pin.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- tx_data  input  8  byte to transmit; sampled only on handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  controller can accept a byte this cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- bit_tick  output  1  one-cycle pulse on the last clock of every bit period; for debug and bench alignment.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, txd=1, tx_ready=1, busy=0, bit_tick=0.
  - Baud counter=0, bit index=0, shift register=0.
  - Applies mid-frame: the frame is abandoned and txd returns to 1 after that edge.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - txd=1, tx_ready=1.
  - On tx_valid&&tx_ready: shift register <= tx_data, bit index <= 0, counter <= 0, state <= START.
  - tx_valid without tx_ready is ignored; the producer holds tx_valid until accepted.
- tx_ready is combinationally equal to (state==IDLE). There is no acceptance outside IDLE, so frames are separated by at least one idle cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_tick=1 when counter==CLKS_PER_BIT-1; counter wraps to 0 on that cycle.
- Advance conditions (all on bit_tick):
  - START: txd=0; advance to DATA.
  - DATA: txd=shift register[0]. Shift right by 1, bit index +1. After index 7 completes, go to PARITY if the feature is enabled, else STOP.
  - STOP: txd=1. Lasts STOP_BITS bit periods (stop counter counts ticks), then IDLE.
- Latency: txd falls on the first clock after the accepting edge.
- Frame length, without parity: CLKS_PER_BIT*(9+STOP_BITS) cycles of busy=1. Add CLKS_PER_BIT with parity.
- Data integrity: tx_data changes after acceptance have no effect on the frame in flight.
- txd is registered (driven from a flop); it must not glitch between bit periods.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA for one bit period; txd = XOR of the accepted 8 data bits (even parity).
  - The parity bit is computed at acceptance and stored in a flop.
- Not defined:
  - No PARITY state or parity flop exists; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - State enum typedef tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - Constant DATA_BITS=8.
  - Constants for idle/start/stop line levels (LINE_IDLE=1, LINE_START=0).
- Sub-module uart_baud_cnt:
  - Parameter CLKS_PER_BIT; inputs clk, rst_n, en.
  - Output tick, asserted when count==CLKS_PER_BIT-1.
  - Counter held at 0 when en=0.
- The FSM and shift register stay in uart_tx_ctrl.

Test Plan:
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, no parity:
  - Stimulus: tx_data=0xA5, one-cycle valid.
  - Required: txd holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; busy=1 for exactly 40 cycles; tx_ready=0 throughout; 10 bit_tick pulses.
- Back-to-back, CLKS_PER_BIT=4:
  - Stimulus: tx_valid held high with 0x00, then 0xFF.
  - Required: second accept occurs on the cycle after the first frame's IDLE returns. Second frame is 0, eight 1s, 1. Exactly one idle cycle (txd=1, busy=0) between frames.
- Reset mid-frame:
  - Stimulus: rst_n=0 for one cycle during data bit 3 of 0x0F.
  - Required: txd=1, tx_ready=1, busy=0 after that edge. A new byte 0x55 accepted afterwards is framed correctly from its start bit.
- STOP_BITS=2, CLKS_PER_BIT=3:
  - Stimulus: send 0x81.
  - Required: stop level high for 6 cycles; busy=1 for 33 cycles.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT=4:
  - Stimulus: send 0xA5, then 0x01.
  - Required: parity bit is 0 for 0xA5 and 1 for 0x01; each frame's busy length is 44 cycles.
- Data hold:
  - Stimulus: change tx_data from 0x3C to 0xC3 on the cycle after acceptance.
  - Required: the transmitted bits correspond to 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick on the last count.
// Held at zero when disabled so each frame starts on a full bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop bit(s).
// txd falls one clock after the accepting edge; tx_ready only in IDLE, so frames are at least one idle cycle apart.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       bit_tick
);

    localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);

    tx_state_t   r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_idx,   w_idx_nxt;
    logic        r_stop_cnt, w_stop_nxt;
    logic        r_txd,   w_txd_nxt;
    logic        w_tick;
    logic        w_idle;

    assign w_idle   = (r_state == IDLE);
    assign tx_ready = w_idle;
    assign busy     = !w_idle;
    assign txd      = r_txd;
    assign bit_tick = w_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!w_idle),
        .tick  (w_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity is taken from the byte as accepted, not from the shifting register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_idle && tx_valid) begin
            r_parity <= ^tx_data;
        end
    end
`endif

    // txd is registered from the next-state line level so it changes exactly on bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_stop_nxt  = r_stop_cnt;
        w_txd_nxt   = r_txd;
        case (r_state)
            IDLE: begin
                w_txd_nxt = LINE_IDLE;
                if (tx_valid) begin
                    w_state_nxt = START;
                    w_shift_nxt = tx_data;
                    w_idx_nxt   = '0;
                    w_stop_nxt  = 1'b0;
                    w_txd_nxt   = LINE_START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_txd_nxt   = r_parity;
`else
                        w_state_nxt = STOP;
                        w_txd_nxt   = LINE_STOP;
`endif
                    end else begin
                        w_txd_nxt = w_shift_nxt[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_txd_nxt   = LINE_STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_txd_nxt   = LINE_IDLE;
                    end else begin
                        w_stop_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_txd_nxt   = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_txd      <= LINE_IDLE;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stop) against a bit-list frame model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic            clk;
    logic [1:0]      rst_n;
    logic [1:0][7:0] tx_data;
    logic [1:0]      tx_valid;
    logic [1:0]      tx_ready;
    logic [1:0]      txd;
    logic [1:0]      busy;
    logic [1:0]      bit_tick;

    int n_cmp = 0;
    int n_mis = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n[0]),
        .tx_data  (tx_data[0]),
        .tx_valid (tx_valid[0]),
        .tx_ready (tx_ready[0]),
        .txd      (txd[0]),
        .busy     (busy[0]),
        .bit_tick (bit_tick[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n[1]),
        .tx_data  (tx_data[1]),
        .tx_valid (tx_valid[1]),
        .tx_ready (tx_ready[1]),
        .txd      (txd[1]),
        .busy     (busy[1]),
        .bit_tick (bit_tick[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int sel);
        return (sel == 0) ? 4 : 3;
    endfunction

    function automatic int nstop(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge of the first idle cycle.
    task automatic xmit(input int sel, input logic [7:0] b, input logic [7:0] after_b, input bit keep_valid);
        logic q[$];
        int   busy_cyc;
        int   ticks;
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        if (PAR_EN) q.push_back(^b);
        for (int i = 0; i < nstop(sel); i++) q.push_back(1'b1);

        tx_data[sel]  = b;
        tx_valid[sel] = 1'b1;
        chk("ready_before_accept", 32'(tx_ready[sel]), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) tx_valid[sel] = 1'b0;
        tx_data[sel] = after_b;

        busy_cyc = 0;
        ticks    = 0;
        for (int bi = 0; bi < q.size(); bi++) begin
            for (int c = 0; c < cpb(sel); c++) begin
                @(negedge clk);
                chk($sformatf("txd[%0d] byte %02h bit %0d cyc %0d", sel, b, bi, c),
                    32'(txd[sel]), 32'(q[bi]));
                chk("ready_in_frame", 32'(tx_ready[sel]), 32'd0);
                chk("tick_position", 32'(bit_tick[sel]), 32'(c == cpb(sel) - 1));
                if (busy[sel] === 1'b1) busy_cyc++;
                if (bit_tick[sel] === 1'b1) ticks++;
            end
        end
        chk($sformatf("busy_len[%0d]", sel), 32'(busy_cyc), 32'(cpb(sel) * q.size()));
        chk($sformatf("tick_count[%0d]", sel), 32'(ticks), 32'(q.size()));

        @(negedge clk);
        chk("idle_busy", 32'(busy[sel]), 32'd0);
        chk("idle_txd", 32'(txd[sel]), 32'd1);
        chk("idle_ready", 32'(tx_ready[sel]), 32'd1);
    endtask

    initial begin
        logic [7:0] rb;
        int         rsel;
        rst_n    = 2'b00;
        tx_valid = 2'b00;
        tx_data  = '0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_txd[%0d]", s), 32'(txd[s]), 32'd1);
            chk($sformatf("reset_ready[%0d]", s), 32'(tx_ready[s]), 32'd1);
            chk($sformatf("reset_busy[%0d]", s), 32'(busy[s]), 32'd0);
            chk($sformatf("reset_tick[%0d]", s), 32'(bit_tick[s]), 32'd0);
        end
        rst_n = 2'b11;
        @(negedge clk);

        // Single byte
        xmit(0, 8'hA5, 8'hA5, 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back with valid held: exactly one idle cycle between frames
        xmit(0, 8'h00, 8'h00, 1'b1);
        xmit(0, 8'hFF, 8'hFF, 1'b0);
        repeat (2) @(negedge clk);

        // Data hold: input changes right after acceptance
        xmit(0, 8'h3C, 8'hC3, 1'b0);
        @(negedge clk);

        // Reset during data bit 3 of 0x0F
        tx_data[0]  = 8'h0F;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_bit3", 32'(txd[0]), 32'd1);
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("midreset_txd", 32'(txd[0]), 32'd1);
        chk("midreset_ready", 32'(tx_ready[0]), 32'd1);
        chk("midreset_busy", 32'(busy[0]), 32'd0);
        chk("midreset_tick", 32'(bit_tick[0]), 32'd0);
        xmit(0, 8'h55, 8'h55, 1'b0);

        // Two stop bits at 3 clocks per bit
        xmit(1, 8'h81, 8'h81, 1'b0);

        // Parity-sensitive byte
        xmit(0, 8'h01, 8'h01, 1'b0);

        // Randomized frames across both instances with random gaps
        for (int k = 0; k < 10; k++) begin
            rsel = int'($urandom_range(0, 1));
            rb   = 8'($urandom);
            xmit(rsel, rb, 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
